// File: rtl/soc_mem_pkg.sv
// Shared types and defaults for the SDRAM port arbiter slice.
package soc_mem_pkg;

   localparam int unsigned ADDR_W_DEF = 25;
   localparam int unsigned DATA_W_DEF = 16;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } arb_state_e;

   typedef logic req_id_t;

   localparam req_id_t ID_R0 = 1'b0;
   localparam req_id_t ID_R1 = 1'b1;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Requester (r0 video, r1 sprite/CPU) and Avalon master signals of the arbiter.
interface sdram_port_arbiter_if #(
   parameter int unsigned ADDR_W = soc_mem_pkg::ADDR_W_DEF,
   parameter int unsigned DATA_W = soc_mem_pkg::DATA_W_DEF
);
   localparam int unsigned BE_W = DATA_W / 8;

   logic              r0_req;
   logic              r0_we;
   logic [ADDR_W-1:0] r0_addr;
   logic [DATA_W-1:0] r0_wdata;
   logic [BE_W-1:0]   r0_be;
   logic              r0_ack;
   logic [DATA_W-1:0] r0_rdata;
   logic              r0_rvalid;

   logic              r1_req;
   logic              r1_we;
   logic [ADDR_W-1:0] r1_addr;
   logic [DATA_W-1:0] r1_wdata;
   logic [BE_W-1:0]   r1_be;
   logic              r1_ack;
   logic [DATA_W-1:0] r1_rdata;
   logic              r1_rvalid;

   logic [ADDR_W-1:0] m_address;
   logic              m_read;
   logic              m_write;
   logic [DATA_W-1:0] m_writedata;
   logic [BE_W-1:0]   m_byteenable;
   logic              m_waitrequest;
   logic [DATA_W-1:0] m_readdata;
   logic              m_readdatavalid;

   // Arbiter side
   modport slave (
      input  r0_req, r0_we, r0_addr, r0_wdata, r0_be,
      output r0_ack, r0_rdata, r0_rvalid,
      input  r1_req, r1_we, r1_addr, r1_wdata, r1_be,
      output r1_ack, r1_rdata, r1_rvalid,
      output m_address, m_read, m_write, m_writedata, m_byteenable,
      input  m_waitrequest, m_readdata, m_readdatavalid
   );

   // Requesters plus SDRAM controller side
   modport master (
      output r0_req, r0_we, r0_addr, r0_wdata, r0_be,
      input  r0_ack, r0_rdata, r0_rvalid,
      output r1_req, r1_we, r1_addr, r1_wdata, r1_be,
      input  r1_ack, r1_rdata, r1_rvalid,
      input  m_address, m_read, m_write, m_writedata, m_byteenable,
      output m_waitrequest, m_readdata, m_readdatavalid
   );

endinterface

// File: rtl/tag_fifo.sv
// Read-owner tag FIFO: remembers which requester issued each outstanding read.
module tag_fifo
   import soc_mem_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  req_id_t                      push_id,
   input  logic                         pop,
   output req_id_t                      head_id,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] mem_q, mem_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign head_id = mem_q[rd_ptr_q];

   // Pointers wrap naturally since DEPTH is a power of two
   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_id;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-requester Avalon SDRAM arbiter: r0 priority with starvation guard, in-order read return.
module sdram_port_arbiter
   import soc_mem_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned MAX_PEND   = 8,
   parameter int unsigned STARVE_LIM = 4
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset_n,
   sdram_port_arbiter_if.slave  bus,
   output logic                 err_orphan
);
   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned SW    = $clog2(STARVE_LIM + 1);
   localparam int unsigned CNT_W = $clog2(MAX_PEND + 1);

   arb_state_e        state_q, state_d;
   logic [ADDR_W-1:0] m_addr_q, m_addr_d;
   logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
   logic [BE_W-1:0]   m_be_q, m_be_d;
   logic              m_read_q, m_read_d;
   logic              m_write_q, m_write_d;
   req_id_t           owner_q, owner_d;
   logic [SW-1:0]     streak_q, streak_d;
   logic              err_q, err_d;

   logic              elig0_c, elig1_c, grant0_c, grant1_c;
   logic              ack0_c, ack1_c, push_c, pop_c;
   logic              fifo_full, fifo_empty;
   req_id_t           head_id;
   logic [CNT_W-1:0]  unused_pend_cnt;

   tag_fifo #(.DEPTH(MAX_PEND)) u_tag_fifo (
      .clk     (clk_clk),
      .rst_n   (reset_reset_n),
      .push    (push_c),
      .push_id (owner_q),
      .pop     (pop_c),
      .head_id (head_id),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (unused_pend_cnt)
   );

   // Reads wait for a free tag slot; writes never need one
   assign elig0_c = bus.r0_req && (bus.r0_we || !fifo_full);
   assign elig1_c = bus.r1_req && (bus.r1_we || !fifo_full);

   assign push_c = (state_q == ST_ISSUE) && !bus.m_waitrequest && m_read_q;
   assign pop_c  = bus.m_readdatavalid && !fifo_empty;

   always_comb begin
      state_d   = state_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      m_be_d    = m_be_q;
      m_read_d  = m_read_q;
      m_write_d = m_write_q;
      owner_d   = owner_q;
      streak_d  = streak_q;
      err_d     = err_q;
      grant0_c  = 1'b0;
      grant1_c  = 1'b0;
      ack0_c    = 1'b0;
      ack1_c    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (elig0_c && !(elig1_c && streak_q == SW'(STARVE_LIM))) begin
               grant0_c = 1'b1;
            end else if (elig1_c) begin
               grant1_c = 1'b1;
            end
            if (grant0_c) begin
               m_addr_d  = bus.r0_addr;
               m_wdata_d = bus.r0_wdata;
               m_be_d    = bus.r0_be;
               m_read_d  = !bus.r0_we;
               m_write_d = bus.r0_we;
               owner_d   = ID_R0;
               state_d   = ST_ISSUE;
            end else if (grant1_c) begin
               m_addr_d  = bus.r1_addr;
               m_wdata_d = bus.r1_wdata;
               m_be_d    = bus.r1_be;
               m_read_d  = !bus.r1_we;
               m_write_d = bus.r1_we;
               owner_d   = ID_R1;
               state_d   = ST_ISSUE;
            end else begin
               m_read_d  = 1'b0;
               m_write_d = 1'b0;
            end
         end
         ST_ISSUE: begin
            if (!bus.m_waitrequest) begin
               ack0_c    = (owner_q == ID_R0);
               ack1_c    = (owner_q == ID_R1);
               m_read_d  = 1'b0;
               m_write_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Starvation streak: counts r0 wins while r1 is waiting
      if (!bus.r1_req || grant1_c) begin
         streak_d = '0;
      end else if (grant0_c && streak_q != SW'(STARVE_LIM)) begin
         streak_d = streak_q + SW'(1);
      end

      if (bus.m_readdatavalid && fifo_empty) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q   <= ST_IDLE;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         m_be_q    <= '0;
         m_read_q  <= 1'b0;
         m_write_q <= 1'b0;
         owner_q   <= ID_R0;
         streak_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         m_be_q    <= m_be_d;
         m_read_q  <= m_read_d;
         m_write_q <= m_write_d;
         owner_q   <= owner_d;
         streak_q  <= streak_d;
         err_q     <= err_d;
      end
   end

   assign bus.m_address    = m_addr_q;
   assign bus.m_writedata  = m_wdata_q;
   assign bus.m_byteenable = m_be_q;
   assign bus.m_read       = m_read_q;
   assign bus.m_write      = m_write_q;

   // Read data is steered to whichever requester owns the FIFO head
   assign bus.r0_ack    = ack0_c;
   assign bus.r1_ack    = ack1_c;
   assign bus.r0_rdata  = bus.m_readdata;
   assign bus.r1_rdata  = bus.m_readdata;
   assign bus.r0_rvalid = pop_c && (head_id == ID_R0);
   assign bus.r1_rvalid = pop_c && (head_id == ID_R1);

   assign err_orphan = err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: priority, starvation, stalls, tag FIFO, orphans, reset.
module tb_sdram_port_arbiter;
   import soc_mem_pkg::*;

   localparam int unsigned AW = 25;
   localparam int unsigned DW = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic err_orphan;
   int   checks   = 0;
   int   failures = 0;

   sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   sdram_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MAX_PEND(8), .STARVE_LIM(4)
   ) dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .bus           (bus),
      .err_orphan    (err_orphan)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic set_req(input int id, input logic on, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd);
      if (id == 0) begin
         bus.r0_req = on; bus.r0_we = we; bus.r0_addr = addr; bus.r0_wdata = wd;
      end else begin
         bus.r1_req = on; bus.r1_we = we; bus.r1_addr = addr; bus.r1_wdata = wd;
      end
   endtask

   // Single requester command: wait (bounded) for ack, release, return to IDLE
   task automatic issue(input int id, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input string tag);
      logic got;
      got = 1'b0;
      set_req(id, 1'b1, we, addr, wd);
      for (int i = 0; i < 20 && !got; i++) begin
         cyc();
         got = (id == 0) ? bus.r0_ack : bus.r1_ack;
      end
      check({tag, "_ack"}, 32'(got), 32'd1);
      set_req(id, 1'b0, we, addr, wd);
      cyc();
   endtask

   task automatic return_word(input int id, input logic [DW-1:0] d, input string tag);
      bus.m_readdatavalid = 1'b1;
      bus.m_readdata      = d;
      #1;
      check({tag, "_rv0"}, 32'(bus.r0_rvalid), (id == 0) ? 32'd1 : 32'd0);
      check({tag, "_rv1"}, 32'(bus.r1_rvalid), (id == 1) ? 32'd1 : 32'd0);
      check({tag, "_rdata"}, 32'((id == 0) ? bus.r0_rdata : bus.r1_rdata), 32'(d));
      cyc();
      bus.m_readdatavalid = 1'b0;
   endtask

   int owners [8] = '{0, 1, 1, 0, 0, 1, 0, 1};

   initial begin
      bus.r0_req = 0; bus.r0_we = 0; bus.r0_addr = '0; bus.r0_wdata = '0; bus.r0_be = 2'b11;
      bus.r1_req = 0; bus.r1_we = 0; bus.r1_addr = '0; bus.r1_wdata = '0; bus.r1_be = 2'b10;
      bus.m_waitrequest = 0; bus.m_readdata = '0; bus.m_readdatavalid = 0;

      #12;
      check("rst_m_read",  32'(bus.m_read), 0);
      check("rst_m_write", 32'(bus.m_write), 0);
      check("rst_m_addr",  32'(bus.m_address), 0);
      check("rst_m_wdata", 32'(bus.m_writedata), 0);
      check("rst_m_be",    32'(bus.m_byteenable), 0);
      check("rst_err",     32'(err_orphan), 0);
      check("rst_ack0",    32'(bus.r0_ack), 0);
      check("rst_rv1",     32'(bus.r1_rvalid), 0);
      rst_n = 1'b1;
      cyc();

      // Both request: r0 first, then r1
      set_req(0, 1, 0, 25'h200, '0);
      set_req(1, 1, 0, 25'h100, '0);
      cyc();
      check("prio_m_read", 32'(bus.m_read), 1);
      check("prio_addr0",  32'(bus.m_address), 32'h200);
      check("prio_ack0",   32'(bus.r0_ack), 1);
      check("prio_ack1a",  32'(bus.r1_ack), 0);
      bus.r0_req = 0;
      cyc();
      check("prio_drop",   32'(bus.m_read), 0);
      cyc();
      check("prio_addr1",  32'(bus.m_address), 32'h100);
      check("prio_ack1",   32'(bus.r1_ack), 1);
      check("prio_ack0b",  32'(bus.r0_ack), 0);
      bus.r1_req = 0;
      cyc();
      check("prio_cnt",    32'(dut.u_tag_fifo.count), 2);
      return_word(0, 16'hAAAA, "prio_ret0");
      return_word(1, 16'hBBBB, "prio_ret1");
      check("prio_cnt0",   32'(dut.u_tag_fifo.count), 0);

      // Starvation guard: r1 write wins after 4 r0 grants
      set_req(1, 1, 1, 25'h10, 16'h55AA);
      set_req(0, 1, 0, 25'h300, '0);
      for (int k = 0; k < 4; k++) begin
         cyc();
         check("stv_ack0",   32'(bus.r0_ack), 1);
         check("stv_ack1",   32'(bus.r1_ack), 0);
         check("stv_addr",   32'(bus.m_address), 32'h300 + 32'(k));
         check("stv_streak", 32'(dut.streak_q), 32'(k + 1));
         bus.r0_addr = 25'h300 + 25'(k + 1);
         cyc();
      end
      cyc();
      check("stv_w",      32'(bus.m_write), 1);
      check("stv_waddr",  32'(bus.m_address), 32'h10);
      check("stv_wdata",  32'(bus.m_writedata), 32'h55AA);
      check("stv_be",     32'(bus.m_byteenable), 32'h2);
      check("stv_r1ack",  32'(bus.r1_ack), 1);
      check("stv_r0ack",  32'(bus.r0_ack), 0);
      check("stv_clear",  32'(dut.streak_q), 0);
      bus.r1_req = 0; bus.r0_req = 0;
      cyc();
      check("stv_cnt",    32'(dut.u_tag_fifo.count), 4);
      for (int k = 0; k < 4; k++) return_word(0, 16'(16'h3000 + k), "stv_ret");

      // Waitrequest stall: outputs frozen, ack only when it drops
      bus.m_waitrequest = 1;
      set_req(1, 1, 1, 25'h20, 16'h1234);
      cyc();
      for (int i = 0; i < 5; i++) begin
         check("wr_hold_w",     32'(bus.m_write), 1);
         check("wr_hold_addr",  32'(bus.m_address), 32'h20);
         check("wr_hold_wdata", 32'(bus.m_writedata), 32'h1234);
         check("wr_hold_noack", 32'(bus.r1_ack), 0);
         cyc();
      end
      bus.m_waitrequest = 0;
      #1;
      check("wr_ack",  32'(bus.r1_ack), 1);
      check("wr_w",    32'(bus.m_write), 1);
      bus.r1_req = 0;
      cyc();
      check("wr_drop", 32'(bus.m_write), 0);

      // Fill all tags, 9th read blocked, write still accepted, in-order return
      for (int i = 0; i < 8; i++) issue(owners[i], 1'b0, 25'h400 + 25'(i), '0, "full_rd");
      check("full_cnt", 32'(dut.u_tag_fifo.count), 8);
      set_req(0, 1, 0, 25'h500, '0);
      set_req(1, 1, 1, 25'h30, 16'hBEEF);
      cyc();
      check("full_w",     32'(bus.m_write), 1);
      check("full_r1ack", 32'(bus.r1_ack), 1);
      check("full_r0ack", 32'(bus.r0_ack), 0);
      bus.r1_req = 0;
      cyc(); cyc(); cyc();
      check("full_blk_ack", 32'(bus.r0_ack), 0);
      check("full_blk_rd",  32'(bus.m_read), 0);
      bus.r0_req = 0;
      check("full_cnt2",    32'(dut.u_tag_fifo.count), 8);
      for (int i = 0; i < 8; i++) return_word(owners[i], 16'(16'hD000 + i), "full_ret");
      check("full_cnt0",    32'(dut.u_tag_fifo.count), 0);

      // Orphan data, then simultaneous push and pop
      bus.m_readdatavalid = 1; bus.m_readdata = 16'hDEAD;
      #1;
      check("orph_rv0", 32'(bus.r0_rvalid), 0);
      check("orph_rv1", 32'(bus.r1_rvalid), 0);
      cyc();
      bus.m_readdatavalid = 0;
      check("orph_err", 32'(err_orphan), 1);
      issue(1, 1'b0, 25'h600, '0, "pp_rd");
      set_req(0, 1, 0, 25'h700, '0);
      cyc();
      bus.m_readdatavalid = 1; bus.m_readdata = 16'h7777;
      #1;
      check("pp_ack0",  32'(bus.r0_ack), 1);
      check("pp_rv1",   32'(bus.r1_rvalid), 1);
      check("pp_rv0",   32'(bus.r0_rvalid), 0);
      bus.r0_req = 0;
      cyc();
      bus.m_readdatavalid = 0;
      check("pp_cnt",   32'(dut.u_tag_fifo.count), 1);
      return_word(0, 16'h8888, "pp_ret");
      check("pp_err",   32'(err_orphan), 1);

      // Reset while issuing with 3 reads pending
      for (int i = 0; i < 3; i++) issue(0, 1'b0, 25'h800 + 25'(i), '0, "rst_rd");
      check("rst_cnt3", 32'(dut.u_tag_fifo.count), 3);
      bus.m_waitrequest = 1;
      set_req(0, 1, 0, 25'h900, '0);
      cyc();
      check("rst_pre_rd", 32'(bus.m_read), 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_mid_rd",   32'(bus.m_read), 0);
      check("rst_mid_addr", 32'(bus.m_address), 0);
      check("rst_mid_cnt",  32'(dut.u_tag_fifo.count), 0);
      check("rst_mid_err",  32'(err_orphan), 0);
      check("rst_mid_ack",  32'(bus.r0_ack), 0);
      bus.r0_req = 0; bus.m_waitrequest = 0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      check("rst_post_rd", 32'(bus.m_read), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, meaning SDRAM Avalon address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning SDRAM data width.
REQ-003 SHALL have parameter MAX_PEND, default 8, meaning maximum outstanding reads (power of 2).
REQ-004 SHALL have parameter STARVE_LIM, default 4, meaning consecutive r0 grants allowed while r1 waits.
REQ-005 SHALL have one clock and an asynchronous active-low reset, ports: clk_clk in 1 system clock; reset_reset_n in 1 async active-low reset.
REQ-006 SHALL have requester ports, x in {0,1}, where r0 is video fetch (priority) and r1 is sprite/CPU: rx_req in 1 request; rx_we in 1 write(1)/read(0); rx_addr in ADDR_W word address; rx_wdata in DATA_W write data; rx_be in DATA_W/8 byte enables; rx_ack out 1 command-accepted pulse; rx_rdata out DATA_W read data; rx_rvalid out 1 read-data pulse.
REQ-007 SHALL have Avalon master ports: m_address out ADDR_W; m_read out 1; m_write out 1; m_writedata out DATA_W; m_byteenable out DATA_W/8; m_waitrequest in 1; m_readdata in DATA_W; m_readdatavalid in 1.
REQ-008 SHALL have err_orphan out 1, sticky flag set when read data arrives with no pending tag.

Function
REQ-009 SHALL implement FSM states IDLE and ISSUE; all m_* command outputs are registered.
REQ-010 IDLE: if an eligible request exists, latch winner's addr/we/wdata/be into m_* registers, assert m_read or m_write, record owner, go to ISSUE; otherwise stay in IDLE with m_read=m_write=0.
REQ-011 ISSUE: hold all m_* outputs stable while m_waitrequest=1; when m_waitrequest=0, drive rx_ack=1 for owner that cycle (combinational), drop m_read/m_write next cycle, return to IDLE.
REQ-012 Requester SHALL hold req and command fields stable until ack; arbiter samples them only in IDLE.
REQ-013 Arbitration: r0 wins when both eligible, except r1 wins when streak==STARVE_LIM.
REQ-014 streak counter: +1 on each r0 grant while r1_req=1; cleared on r1 grant or any cycle r1_req=0; saturates at STARVE_LIM.
REQ-015 A read request is ineligible while tag FIFO holds MAX_PEND entries; writes remain eligible.
REQ-016 On read acceptance (ISSUE and m_waitrequest=0 and m_read=1) SHALL push owner ID into tag FIFO.
REQ-017 On m_readdatavalid=1 SHALL pop FIFO head and drive rx_rdata=m_readdata, rx_rvalid=1 for popped ID in the same cycle (combinational routing); other requester's rvalid=0.
REQ-018 Simultaneous push and pop SHALL both occur; occupancy unchanged; FIFO pointers wrap modulo MAX_PEND.
REQ-019 m_readdatavalid with empty FIFO SHALL be dropped, no rvalid, and set err_orphan until reset.
REQ-020 Read data SHALL be returned strictly in issue order; throughput is one command per two cycles minimum.

Reset
REQ-021 On reset_reset_n=0 (asynchronous) SHALL force state=IDLE, m_read=m_write=0, m_address/m_writedata=0, m_byteenable=0, streak=0, FIFO empty, err_orphan=0; rx_ack/rx_rvalid=0.
REQ-022 Reset mid-ISSUE or with reads pending SHALL discard the command and all tags; SDRAM controller shares the same reset.

Structure
REQ-023 Package soc_mem_pkg SHALL hold ADDR_W/DATA_W defaults, arbiter state enum, and 1-bit requester ID type.
REQ-024 Tag FIFO SHALL be sub-module tag_fifo (depth MAX_PEND, width 1, push/pop/full/empty/count).

Verification
REQ-025 Both req high, r1 read 0x100 and r0 read 0x200, waitrequest=0 -> r0 granted first; m_address=0x200; r0_ack pulse; then r1.
REQ-026 r0 continuous reads, r1 holds write 0x55AA@0x10 -> after 4 r0 grants, r1 granted, r1_ack, streak cleared.
REQ-027 waitrequest=1 for 5 cycles during r1 write -> m_* stable 5 cycles; ack only on cycle waitrequest falls.
REQ-028 Issue 8 reads with readdatavalid withheld -> 9th read blocked, r1 write still accepted; return 8 words -> routed in issue order to correct rvalid.
REQ-029 readdatavalid with FIFO empty -> no rvalid, err_orphan=1; push and pop same cycle -> count unchanged.
REQ-030 reset_reset_n low mid-ISSUE with 3 reads pending -> m_read=0 immediately, FIFO empty, err_orphan=0.
